fixp_denorm: RTL and testbench

//  Multi-cycle denormaliser: inverse of the leading-zero-count normalisation step. Takes a

---
 rtl/fixp_denorm_pkg.sv | 11 +
 rtl/fixp_denorm_if.sv | 27 ++
 rtl/fixp_shr_sticky.sv | 27 ++
 rtl/fixp_denorm.sv | 135 +++++++++++++
 tb/tb_fixp_denorm.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fixp_denorm_pkg.sv
// Shared fixed-point parameters for the denormaliser and its neighbours.
package fixp_denorm_pkg;
    // Qm.Qn format of the tracer reciprocal/division results
    localparam int QM         = 8;
    localparam int QN         = 16;
    localparam int FIXP_WIDTH = QM + QN;
    // Default right-shift distance handled per cycle
    localparam int FIXP_STEP  = 4;
    // Shift-count width coming from the LZC (0..127)
    localparam int CNT_W      = 7;
endpackage

// File: rtl/fixp_denorm_if.sv
// Valid/ready request + result bundle for fixp_denorm.
interface fixp_denorm_if
    import fixp_denorm_pkg::*;
#(
    parameter int WIDTH = FIXP_WIDTH
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_mant;
    logic [CNT_W-1:0] i_cnt;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_inexact;

    // Producer/consumer side (drives requests, accepts results)
    modport master (
        output i_valid, i_mant, i_cnt, i_ready,
        input  o_ready, o_valid, o_data, o_inexact
    );

    // Denormaliser side
    modport slave (
        input  i_valid, i_mant, i_cnt, i_ready,
        output o_ready, o_valid, o_data, o_inexact
    );
endinterface

// File: rtl/fixp_shr_sticky.sv
// One combinational right-shift step (0..STEP bits) that also reports the
// last bit shifted out (guard) and the OR of everything below it (sticky).
module fixp_shr_sticky #(
    parameter int WIDTH = 24,
    parameter int SHW   = 3
) (
    input  logic [WIDTH-1:0] din_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             guard_o,
    output logic             sticky_o
);

    // Bit shamt-1 becomes the guard; all bits beneath it fold into sticky
    always_comb begin
        dout_o   = din_i >> shamt_i;
        guard_o  = 1'b0;
        sticky_o = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i + 1 == int'(shamt_i))
                guard_o = din_i[i];
            else if (i + 1 < int'(shamt_i))
                sticky_o = sticky_o | din_i[i];
        end
    end

endmodule

// File: rtl/fixp_denorm.sv
// Multi-cycle denormaliser: right-shifts a left-justified mantissa by the LZC
// count, STEP bits per cycle, then rounds to nearest with ties away from zero.
module fixp_denorm
    import fixp_denorm_pkg::*;
#(
    parameter int WIDTH = FIXP_WIDTH,
    parameter int STEP  = FIXP_STEP
) (
    input  logic          clk,
    input  logic          reset_n,
    fixp_denorm_if.slave  bus
);

`ifndef OPENLANE
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("fixp_denorm: WIDTH must be 1..64");
    end
    if (STEP < 1 || STEP > WIDTH || (STEP & (STEP - 1)) != 0) begin : g_bad_step
        $error("fixp_denorm: STEP must be a power of 2 in 1..WIDTH");
    end
`endif

    localparam int SHW = $clog2(STEP + 1);
    // Beyond WIDTH+1 every data bit and the guard are gone; further shifting is moot
    localparam logic [CNT_W-1:0] REM_MAX = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             guard_q, guard_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             inexact_q, inexact_d;
    logic             valid_q, valid_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] shr_out;
    logic             shr_guard;
    logic             shr_sticky;

    // This cycle's shift distance: whatever remains, capped at STEP
    assign shamt = (rem_q > STEP_C) ? SHW'(STEP) : SHW'(rem_q);

    fixp_shr_sticky #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shr (
        .din_i    (sh_q),
        .shamt_i  (shamt),
        .dout_o   (shr_out),
        .guard_o  (shr_guard),
        .sticky_o (shr_sticky)
    );

    assign bus.o_ready   = (state_q == IDLE);
    assign bus.o_valid   = valid_q;
    assign bus.o_data    = data_q;
    assign bus.o_inexact = inexact_q;

    // State and datapath registers; reset aborts any job in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            rem_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            data_q    <= '0;
            inexact_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            rem_q     <= rem_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            data_q    <= data_d;
            inexact_q <= inexact_d;
            valid_q   <= valid_d;
        end
    end

    // Next state: accept in IDLE, shift until rem hits 0, round, hold until taken
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        rem_d     = rem_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        data_d    = data_q;
        inexact_d = inexact_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    state_d  = SHIFT;
                    sh_d     = bus.i_mant;
                    rem_d    = (bus.i_cnt > REM_MAX) ? REM_MAX : bus.i_cnt;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                end
            end
            SHIFT: begin
                if (rem_q != '0) begin
                    sh_d     = shr_out;
                    guard_d  = shr_guard;
                    // Previous guard is no longer the round bit, so it joins sticky
                    sticky_d = sticky_q | guard_q | shr_sticky;
                    rem_d    = rem_q - CNT_W'(shamt);
                end else begin
                    // Cannot carry out: a real shift clears the MSB, no shift leaves guard 0
                    data_d    = sh_q + WIDTH'(guard_q);
                    inexact_d = guard_q | sticky_q;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fixp_denorm.sv
// Directed bench for fixp_denorm (WIDTH=24, STEP=4): vector table plus
// hand-written stall and mid-job reset sequences.
module tb_fixp_denorm;
    import fixp_denorm_pkg::*;

    localparam int W = 24;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    fixp_denorm_if #(.WIDTH(W)) bus ();

    fixp_denorm #(.WIDTH(W), .STEP(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] mant;
        logic [6:0]   cnt;
        logic [W-1:0] data;
        logic         inex;
        int           lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one job, wait for the result (bounded) and check data, flag, latency
    task automatic run_job(input string tag, input logic [W-1:0] mant, input logic [6:0] cnt,
                           input logic [W-1:0] exp_d, input logic exp_x, input int exp_lat,
                           input logic rdy);
        int lat;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
        bus.i_valid = 1'b1;
        bus.i_mant  = mant;
        bus.i_cnt   = cnt;
        bus.i_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        lat = 0;
        if (!bus.o_valid) begin
            for (lat = 1; lat <= 100; lat++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.o_valid) break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, 64'(bus.o_data), 64'(exp_d));
        chk({tag, "_inex"}, 64'(bus.o_inexact), 64'(exp_x));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //           mant        cnt    data        inex  lat
        vecs[0]  = '{24'h800000, 7'd0,   24'h800000, 1'b0, 1};
        vecs[1]  = '{24'hC00000, 7'd5,   24'h060000, 1'b0, 3};
        vecs[2]  = '{24'h800003, 7'd2,   24'h200001, 1'b1, 2};
        vecs[3]  = '{24'h800002, 7'd2,   24'h200001, 1'b1, 2};
        vecs[4]  = '{24'h800000, 7'd24,  24'h000001, 1'b1, 7};
        vecs[5]  = '{24'h800000, 7'd30,  24'h000000, 1'b1, 8};
        vecs[6]  = '{24'h800001, 7'd1,   24'h400001, 1'b1, 2};
        vecs[7]  = '{24'h000000, 7'd10,  24'h000000, 1'b0, 4};
        vecs[8]  = '{24'hFFFFFF, 7'd4,   24'h100000, 1'b1, 2};
        vecs[9]  = '{24'h800000, 7'd127, 24'h000000, 1'b1, 8};
        vecs[10] = '{24'hA00000, 7'd25,  24'h000000, 1'b1, 8};
        vecs[11] = '{24'h900000, 7'd20,  24'h000009, 1'b0, 6};
        vecs[12] = '{24'h880000, 7'd21,  24'h000004, 1'b1, 7};
        vecs[13] = '{24'hC00000, 7'd23,  24'h000002, 1'b1, 7};

        bus.i_valid = 1'b0;
        bus.i_mant  = '0;
        bus.i_cnt   = '0;
        bus.i_ready = 1'b1;
        reset_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_data", 64'(bus.o_data), 64'd0);
        chk("rst_inex", 64'(bus.o_inexact), 64'd0);
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        reset_n = 1'b1;

        // Table vectors with downstream always ready
        for (int k = 0; k < 14; k++) begin
            run_job($sformatf("vec%0d", k), vecs[k].mant, vecs[k].cnt,
                    vecs[k].data, vecs[k].inex, vecs[k].lat, 1'b1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_drop", k), 64'(bus.o_valid), 64'd0);
            chk($sformatf("vec%0d_rdy", k), 64'(bus.o_ready), 64'd1);
        end

        // Downstream stall: result held, new requests ignored
        run_job("stall", 24'hC00000, 7'd5, 24'h060000, 1'b0, 3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bus.i_valid = 1'b1;
            bus.i_mant  = 24'hFFFFFF;
            bus.i_cnt   = 7'd1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), 64'(bus.o_valid), 64'd1);
            chk($sformatf("stall%0d_data", k), 64'(bus.o_data), 64'h060000);
            chk($sformatf("stall%0d_inex", k), 64'(bus.o_inexact), 64'd0);
            chk($sformatf("stall%0d_ready", k), 64'(bus.o_ready), 64'd0);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_release_valid", 64'(bus.o_valid), 64'd0);
        chk("stall_release_ready", 64'(bus.o_ready), 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_no_ghost", 64'(bus.o_valid), 64'd0);

        // Reset in the middle of a long shift: job is dropped
        bus.i_valid = 1'b1;
        bus.i_mant  = 24'h800000;
        bus.i_cnt   = 7'd30;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(bus.o_ready), 64'd0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_rst_valid", 64'(bus.o_valid), 64'd0);
        chk("mid_rst_data", 64'(bus.o_data), 64'd0);
        chk("mid_rst_ready", 64'(bus.o_ready), 64'd1);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.o_valid) seen++;
            end
            chk("mid_rst_no_stale", 64'(seen), 64'd0);
        end

        // Block still works after the abort
        run_job("post_rst", 24'h800003, 7'd2, 24'h200001, 1'b1, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
